// File: rtl/crc_frame_pack.sv
// crc_frame_pack: captures a payload burst, appends CRC-16/CCITT-FALSE and re-emits it as an EB 90 TYPE LEN PAYLOAD CRC frame
module crc_frame_pack #(
  parameter int          MAX_LEN  = 64,
  parameter logic [7:0]  HEAD0    = 8'hEB,
  parameter logic [7:0]  HEAD1    = 8'h90,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic       sys_clk_i,
  input  logic       rst_i,
  input  logic [7:0] para_type_i,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic [7:0] frm_data_o,
  output logic       frm_valid_o,
  input  logic       frm_ready_i,
  output logic       frm_sof_o,
  output logic       frm_eof_o,
  output logic       busy_o,
  output logic       ovf_err_o,
  output logic       drop_err_o
);
  localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] ML = 8'(MAX_LEN);
  typedef enum logic [3:0] {IDLE, CAPT, SEND_H0, SEND_H1, SEND_TYPE, SEND_LEN, SEND_PAY, SEND_CRCH, SEND_CRCL} state_t;
  state_t state;
  logic [7:0] mem [0:MAX_LEN-1];
  logic [7:0] cnt, idx, typ;
  logic [15:0] crc;
  logic skip, send, acc, wr_en;
  logic [AW-1:0] wa;
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? {r[14:0], 1'b0} ^ 16'h1021 : {r[14:0], 1'b0};
    return r;
  endfunction
  assign send  = state >= SEND_H0;
  assign acc   = frm_valid_o & frm_ready_i;
  assign wr_en = !rst_i && data_valid && ((state == IDLE && !skip) || (state == CAPT && cnt != ML));
  assign wa    = state == IDLE ? '0 : cnt[AW-1:0];
  always_ff @(posedge sys_clk_i)
    if (wr_en) mem[wa] <= data_in;
  // skip stays set until the offending burst ends, so its tail is never captured
  always_ff @(posedge sys_clk_i) begin
    ovf_err_o  <= 1'b0;
    drop_err_o <= 1'b0;
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      typ         <= '0;
      crc         <= CRC_INIT;
      skip        <= 1'b0;
      frm_data_o  <= '0;
      frm_valid_o <= 1'b0;
      frm_sof_o   <= 1'b0;
      frm_eof_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      if (send && data_valid) begin
        drop_err_o <= 1'b1;
        skip       <= 1'b1;
      end else if (!data_valid) skip <= 1'b0;
      case (state)
        IDLE: if (data_valid && !skip) begin
          cnt   <= 8'd1;
          typ   <= para_type_i;
          crc   <= crc_step(CRC_INIT, data_in);
          state <= CAPT;
        end
        CAPT: if (data_valid) begin
          if (cnt == ML) ovf_err_o <= 1'b1;
          else begin
            cnt <= cnt + 8'd1;
            crc <= crc_step(crc, data_in);
          end
        end else begin
          state       <= SEND_H0;
          frm_valid_o <= 1'b1;
          frm_data_o  <= HEAD0;
          frm_sof_o   <= 1'b1;
          busy_o      <= 1'b1;
        end
        default: if (acc) begin
          case (state)
            SEND_H0: begin
              frm_data_o <= HEAD1;
              frm_sof_o  <= 1'b0;
              state      <= SEND_H1;
            end
            SEND_H1: begin
              frm_data_o <= typ;
              state      <= SEND_TYPE;
            end
            SEND_TYPE: begin
              frm_data_o <= cnt;
              state      <= SEND_LEN;
            end
            SEND_LEN: begin
              frm_data_o <= mem[0];
              idx        <= 8'd1;
              state      <= SEND_PAY;
            end
            SEND_PAY: if (idx == cnt) begin
              frm_data_o <= crc[15:8];
              state      <= SEND_CRCH;
            end else begin
              frm_data_o <= mem[idx[AW-1:0]];
              idx        <= idx + 8'd1;
            end
            SEND_CRCH: begin
              frm_data_o <= crc[7:0];
              frm_eof_o  <= 1'b1;
              state      <= SEND_CRCL;
            end
            default: begin
              frm_data_o  <= '0;
              frm_valid_o <= 1'b0;
              frm_eof_o   <= 1'b0;
              busy_o      <= 1'b0;
              cnt         <= '0;
              idx         <= '0;
              crc         <= CRC_INIT;
              state       <= IDLE;
            end
          endcase
        end
      endcase
    end
  end
endmodule

// File: tb/tb_crc_frame_pack.sv
// tb_crc_frame_pack: directed frame checks with an accepted-byte monitor and stall-stability checks
module tb_crc_frame_pack;
  logic       sys_clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] para_type_i = '0;
  logic [7:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic       frm_ready_i = 1'b1;
  logic [7:0] frm_data_o;
  logic       frm_valid_o, frm_sof_o, frm_eof_o, busy_o, ovf_err_o, drop_err_o;
  int checks = 0, errors = 0, cyc = 0, ovf_cnt = 0, drop_cnt = 0;
  bit rand_rdy = 1'b0;
  logic [7:0] q_data[$];
  logic       q_sof[$], q_eof[$];
  int         q_cyc[$];
  logic       prev_stall = 1'b0;
  logic [9:0] prev_out = '0;
  logic [7:0] t1[$], t2[$], t4[$], t5[$], e1[$], e2[$], e4[$];
  logic [15:0] c4;
  crc_frame_pack dut (
    .sys_clk_i(sys_clk_i), .rst_i(rst_i), .para_type_i(para_type_i),
    .data_in(data_in), .data_valid(data_valid), .frm_data_o(frm_data_o),
    .frm_valid_o(frm_valid_o), .frm_ready_i(frm_ready_i), .frm_sof_o(frm_sof_o),
    .frm_eof_o(frm_eof_o), .busy_o(busy_o), .ovf_err_o(ovf_err_o), .drop_err_o(drop_err_o)
  );
  always #5 sys_clk_i = ~sys_clk_i;
  always @(posedge sys_clk_i) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] crc_ref(input logic [7:0] d[$]);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    foreach (d[i])
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ d[i][b];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    return c;
  endfunction
  initial forever begin
    @(posedge sys_clk_i);
    #1;
    frm_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  always @(negedge sys_clk_i) begin
    if (prev_stall && frm_valid_o) check("stable", {22'd0, frm_data_o, frm_sof_o, frm_eof_o}, {22'd0, prev_out});
    prev_stall = frm_valid_o && !frm_ready_i;
    prev_out   = {frm_data_o, frm_sof_o, frm_eof_o};
    if (frm_valid_o && frm_ready_i) begin
      q_data.push_back(frm_data_o);
      q_sof.push_back(frm_sof_o);
      q_eof.push_back(frm_eof_o);
      q_cyc.push_back(cyc);
    end
    ovf_cnt  += int'(ovf_err_o);
    drop_cnt += int'(drop_err_o);
  end
  task automatic clear_q();
    q_data.delete();
    q_sof.delete();
    q_eof.delete();
    q_cyc.delete();
  endtask
  task automatic drive_burst(input logic [7:0] t, input logic [7:0] b[$]);
    foreach (b[i]) begin
      @(posedge sys_clk_i);
      #1;
      data_valid  = 1'b1;
      data_in     = b[i];
      para_type_i = t;
    end
    @(posedge sys_clk_i);
    #1;
    data_valid = 1'b0;
  endtask
  task automatic wait_frame(input string tag, input int n);
    for (int i = 0; i < 3000 && q_data.size() < n; i++) @(negedge sys_clk_i);
    check({tag, "_done"}, 32'(q_data.size() >= n), 32'd1);
    repeat (2) @(negedge sys_clk_i);
    check({tag, "_idle"}, {30'd0, frm_valid_o, busy_o}, 32'd0);
  endtask
  task automatic check_frame(input string tag, input logic [7:0] e[$]);
    check({tag, "_len"}, 32'(q_data.size()), 32'(e.size()));
    foreach (e[i])
      if (i < q_data.size()) begin
        check($sformatf("%s_byte%0d", tag, i), {24'd0, q_data[i]}, {24'd0, e[i]});
        check($sformatf("%s_sof%0d", tag, i), {31'd0, q_sof[i]}, {31'd0, i == 0});
        check($sformatf("%s_eof%0d", tag, i), {31'd0, q_eof[i]}, {31'd0, i == e.size() - 1});
      end
    clear_q();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end
  initial begin
    t1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    e1 = '{8'hEB, 8'h90, 8'h30, 8'h09, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
    t2 = '{8'h00};
    e2 = '{8'hEB, 8'h90, 8'h10, 8'h01, 8'h00, 8'hE1, 8'hF0};
    t5 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int i = 0; i < 70; i++) t4.push_back(8'(i));
    repeat (3) @(posedge sys_clk_i);
    @(negedge sys_clk_i);
    check("reset_outs", {19'd0, frm_data_o, frm_valid_o, frm_sof_o, frm_eof_o, busy_o, ovf_err_o, drop_err_o}, 32'd0);
    @(posedge sys_clk_i);
    #1;
    rst_i = 1'b0;
    // T1: nine-byte payload with ready held high, frame must be gapless
    drive_burst(8'h30, t1);
    wait_frame("t1", 15);
    if (q_cyc.size() == 15) check("t1_span", 32'(q_cyc[14] - q_cyc[0]), 32'd14);
    check_frame("t1", e1);
    // T2: minimum frame and valid-rise latency
    @(posedge sys_clk_i);
    #1;
    data_valid  = 1'b1;
    data_in     = 8'h00;
    para_type_i = 8'h10;
    @(posedge sys_clk_i);
    #1;
    data_valid = 1'b0;
    @(negedge sys_clk_i);
    check("t2_pre", {31'd0, frm_valid_o}, 32'd0);
    @(negedge sys_clk_i);
    check("t2_rise", {21'd0, frm_valid_o, frm_sof_o, busy_o, frm_data_o}, {21'd0, 3'b111, 8'hEB});
    wait_frame("t2", 7);
    check_frame("t2", e2);
    // T3: random backpressure
    rand_rdy = 1'b1;
    drive_burst(8'h30, t1);
    wait_frame("t3", 15);
    rand_rdy = 1'b0;
    check_frame("t3", e1);
    // T4: overflow, only the first 64 bytes are framed
    ovf_cnt = 0;
    drive_burst(8'h20, t4);
    wait_frame("t4", 70);
    check("t4_ovf", 32'(ovf_cnt), 32'd6);
    e4 = '{8'hEB, 8'h90, 8'h20, 8'h40};
    t4 = t4[0:63];
    foreach (t4[i]) e4.push_back(t4[i]);
    c4 = crc_ref(t4);
    e4.push_back(c4[15:8]);
    e4.push_back(c4[7:0]);
    check_frame("t4", e4);
    // T5: burst arriving during payload transmission is dropped whole
    drop_cnt = 0;
    drive_burst(8'h30, t1);
    repeat (5) @(posedge sys_clk_i);
    drive_burst(8'h55, t5);
    wait_frame("t5", 15);
    check("t5_drop", 32'(drop_cnt), 32'd4);
    check_frame("t5", e1);
    repeat (5) @(negedge sys_clk_i);
    check("t5_noframe", 32'(q_data.size()), 32'd0);
    // T6: reset mid-payload abandons the frame
    drive_burst(8'h30, t1);
    repeat (6) @(posedge sys_clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge sys_clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge sys_clk_i);
    check("t6_rst_outs", {19'd0, frm_data_o, frm_valid_o, frm_sof_o, frm_eof_o, busy_o, ovf_err_o, drop_err_o}, 32'd0);
    clear_q();
    repeat (3) @(negedge sys_clk_i);
    check("t6_quiet", {29'd0, frm_valid_o, busy_o, 1'(q_data.size() != 0)}, 32'd0);
    drive_burst(8'h10, t2);
    wait_frame("t6", 7);
    check_frame("t6", e2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
